// File: rtl/csi2_pkg.sv
// Shared CSI-2 payload definitions: RGB565 pixel layout and the 32-bit pair word
// that the TX packer produces and the RX decoder unpacks.
package csi2_pkg;

  localparam int unsigned PIX_W  = 16;
  localparam int unsigned WORD_W = 32;

  localparam logic [5:0] RGB565_DATA_TYPE = 6'h22;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HALF  = 1'b1
  } pack_state_e;

  // Even pixel in the low half, odd pixel in the high half.
  function automatic logic [WORD_W-1:0] pix_pair(input rgb565_t lo, input rgb565_t hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/rgb565_packer.sv
// Packs RGB565 pixel pairs into 32-bit CSI-2 payload words, pads odd-length lines
// and reports the per-line payload byte count alongside the last word.
module rgb565_packer
  import csi2_pkg::*;
#(
  parameter logic [15:0] PAD_PIXEL   = 16'h0000,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4:0]             pixel_r,
  input  logic [5:0]             pixel_g,
  input  logic [4:0]             pixel_b,
  input  logic                   pixel_valid,
  input  logic                   pixel_line_end,
  output logic                   pixel_ready,
  output logic [31:0]            image_data,
  output logic                   image_data_enable,
  input  logic                   image_data_ready,
  output logic                   image_data_upper_valid,
  output logic                   image_data_last,
  output logic [COUNT_WIDTH-1:0] line_byte_count,
  output logic                   line_overflow
);

  localparam int unsigned SUM_W = COUNT_WIDTH + 1;

  pack_state_e            state_q, state_d;
  rgb565_t                low_q, low_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0]      data_q, data_d;
  logic                   en_q, en_d;
  logic                   upper_q, upper_d;
  logic                   last_q, last_d;
  logic [COUNT_WIDTH-1:0] lbc_q, lbc_d;
  logic                   ovf_q, ovf_d;

  rgb565_t                pix_c;
  logic                   accept_c;
  logic [SUM_W-1:0]       cnt_sum_c;
  logic                   cnt_sat_c;
  logic [COUNT_WIDTH-1:0] cnt_inc_c;

  assign pix_c       = rgb565_t'({pixel_r, pixel_g, pixel_b});
  assign pixel_ready = !en_q || image_data_ready;
  assign accept_c    = pixel_valid && pixel_ready;

  // Byte count including the pixel being accepted, saturating at all-ones.
  assign cnt_sum_c = {1'b0, cnt_q} + SUM_W'(2);
  assign cnt_sat_c = cnt_sum_c[COUNT_WIDTH];
  assign cnt_inc_c = cnt_sat_c ? '1 : cnt_sum_c[COUNT_WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_EMPTY;
      low_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      upper_q <= 1'b0;
      last_q  <= 1'b0;
      lbc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      en_q    <= en_d;
      upper_q <= upper_d;
      last_q  <= last_d;
      lbc_q   <= lbc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    low_d   = low_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    en_d    = en_q;
    upper_d = upper_q;
    last_d  = last_q;
    lbc_d   = lbc_q;
    ovf_d   = ovf_q;

    if (en_q && image_data_ready) begin
      en_d = 1'b0;
    end

    if (accept_c) begin
      if (cnt_sat_c) begin
        ovf_d = 1'b1;
      end
      unique case (state_q)
        S_EMPTY: begin
          if (pixel_line_end) begin
            data_d  = pix_pair(pix_c, rgb565_t'(PAD_PIXEL));
            en_d    = 1'b1;
            upper_d = 1'b0;
            last_d  = 1'b1;
            lbc_d   = cnt_inc_c;
            cnt_d   = '0;
          end else begin
            low_d   = pix_c;
            cnt_d   = cnt_inc_c;
            state_d = S_HALF;
          end
        end
        S_HALF: begin
          data_d  = pix_pair(low_q, pix_c);
          en_d    = 1'b1;
          upper_d = 1'b1;
          last_d  = pixel_line_end;
          lbc_d   = cnt_inc_c;
          cnt_d   = pixel_line_end ? '0 : cnt_inc_c;
          state_d = S_EMPTY;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  assign image_data             = data_q;
  assign image_data_enable      = en_q;
  assign image_data_upper_valid = upper_q;
  assign image_data_last        = last_q;
  assign line_byte_count        = lbc_q;
  assign line_overflow          = ovf_q;

endmodule

// File: doc/rgb565_packer.md
Name: rgb565_packer

Overview:
Transmit-side RGB565 pixel packer for the CSI-2 TX path. It accepts one RGB565 pixel per handshake and packs pixel pairs into 32-bit payload words: the even pixel goes in [15:0] and the odd pixel in [31:16]. The output is in the exact word format the RX-side RGB565 decoder unpacks. The block also pads odd-length lines and reports the per-line payload byte count used for the long-packet header word count.

Parameters:
PAD_PIXEL, 16'h0000, value placed in [31:16] when a line ends on an even-indexed pixel
COUNT_WIDTH, 16, width of line byte counter (CSI-2 WC field width)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
pixel_r  input  5  red component
pixel_g  input  6  green component
pixel_b  input  5  blue component
pixel_valid  input  1  pixel present
pixel_line_end  input  1  qualifies pixel as last of line
pixel_ready  output  1  block can accept pixel this cycle
image_data  output  32  packed payload word
image_data_enable  output  1  image_data valid
image_data_ready  input  1  downstream accepts word
image_data_upper_valid  output  1  [31:16] holds a real pixel (0 = pad)
image_data_last  output  1  word is last of line
line_byte_count  output  COUNT_WIDTH  real payload bytes in line, valid when image_data_last=1
line_overflow  output  1  sticky: line byte count saturated

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high; port names are clock and reset.
- Pixel format: pix = {pixel_r, pixel_g, pixel_b}, i.e. r in [15:11], g in [10:5], b in [4:0].
- Accept: a pixel is accepted when pixel_valid && pixel_ready. pixel_ready = !image_data_enable || image_data_ready. This is combinational from the output register state and image_data_ready, with no loop through pixel_valid.
- Output handshake: a word is consumed when image_data_enable && image_data_ready. The output register holds image_data, upper_valid, last and line_byte_count stable while enable=1 and ready=0. enable deasserts after consumption unless a new word is loaded in the same cycle.
- State machine:
  - EMPTY, no pending half. Accepted pixel with line_end=0 → latch pix as low half, go to HALF, no output. Accepted pixel with line_end=1 → load {PAD_PIXEL, pix}, upper_valid=0, last=1, stay in EMPTY.
  - HALF, low half held. Accepted pixel → load {pix, low}, upper_valid=1, last=pixel_line_end, go to EMPTY.
- Latency: the word is visible the cycle after the accepting edge of its final pixel.
- Byte counter:
  - +2 per accepted pixel.
  - The value presented with a last word includes that word's pixels.
  - Cleared to 0 after a last word is loaded.
  - Saturates at all-ones and sets line_overflow. line_overflow clears only on reset.
- line_byte_count output: holds the count loaded with the word; its value is don't-care when last=0.
- Simultaneous load and drain: the output register may be consumed and reloaded in the same cycle, giving full throughput of one pixel per cycle.
- Reset, including mid-line or mid-stall:
  - State EMPTY, held half and counter discarded.
  - image_data=0, image_data_enable=0, upper_valid=0, last=0, line_byte_count=0, line_overflow=0.
  - pixel_ready=1 in the first cycle after reset.
- pixel_line_end is ignored when pixel_valid=0.

Decomposition:
- Shared package csi2_pkg: rgb565_t packed struct {r[4:0], g[5:0], b[5:0]->b[4:0]}, constant RGB565_DATA_TYPE=6'h22, and a pack function pix_pair(lo, hi) returning the 32-bit word. The RX decoder uses the same word layout.
- No sub-module. The output register and state machine stay in a single module, roughly 150–200 lines of RTL.

Test Plan:
1. Four pixels 0x1111, 0x2222, 0x3333, 0x4444 (last on 4th), ready=1 → words 0x22221111 (last=0) then 0x44443333 (last=1, count=8, upper_valid=1). Each word appears one cycle after its 2nd pixel.
2. Three pixels 0xF800, 0x07E0, 0x001F (last on 3rd) → 0x07E0F800, then 0x0000001F with upper_valid=0, last=1, count=6.
3. Backpressure: hold image_data_ready=0 for 5 cycles with a word pending and pixel_valid=1 → pixel_ready=0, word stable, no pixel lost. Release → stream resumes at one pixel per cycle.
4. Single-pixel line 0xABCD with line_end → immediate word 0x0000ABCD, last=1, count=2. The next line's count restarts at 0.
5. Reset asserted in HALF with a pending low half 0x1234, then pixels 0x5555, 0x6666 → output 0x66665555. 0x1234 never appears and all outputs are 0 during reset.
6. COUNT_WIDTH=4, eight pixels without line_end then line_end → count saturates at 0xF and line_overflow=1, staying 1 until reset.
